// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-port arbiter sharing the ternary RAM between loader, CPU and debug
// Optional feature macro: MEM_ARB_STATS_EN (adds saturating grant/stall counters).
// Ports:
//   clock, reset          : clock, synchronous active-low reset
//   ld_/cpu_/dbg_ req/we/addr/wdata : per-requester access request
//   ld_lock               : loader asks for exclusive ownership
//   *_gnt                 : combinational grant, one-hot or none
//   *_rvalid, rdata       : read return one cycle after a read grant
//   addr_err              : pulse one cycle after a grant with an illegal address
//   mem_*                 : RAM side (mem_read_data valid one cycle after mem_read)
//   locked                : high while the loader owns the RAM
//   ld/cpu/dbg_grants, cpu/dbg_stalls : counters, only with MEM_ARB_STATS_EN
module mem_arbiter #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 9
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ld_req,
  input  logic                       cpu_req,
  input  logic                       dbg_req,
  input  logic                       ld_we,
  input  logic                       cpu_we,
  input  logic                       dbg_we,
  input  logic [2*MEM_ADDR_SIZE-1:0] ld_addr,
  input  logic [2*MEM_ADDR_SIZE-1:0] cpu_addr,
  input  logic [2*MEM_ADDR_SIZE-1:0] dbg_addr,
  input  logic [2*WORD_SIZE-1:0]     ld_wdata,
  input  logic [2*WORD_SIZE-1:0]     cpu_wdata,
  input  logic [2*WORD_SIZE-1:0]     dbg_wdata,
  input  logic                       ld_lock,
  output logic                       ld_gnt,
  output logic                       cpu_gnt,
  output logic                       dbg_gnt,
  output logic                       ld_rvalid,
  output logic                       cpu_rvalid,
  output logic                       dbg_rvalid,
  output logic [2*WORD_SIZE-1:0]     rdata,
  output logic                       addr_err,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_address,
  output logic [2*WORD_SIZE-1:0]     mem_write_data,
  output logic                       mem_write,
  output logic                       mem_read,
  input  logic [2*WORD_SIZE-1:0]     mem_read_data,
  output logic                       locked
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]                ld_grants,
  output logic [15:0]                cpu_grants,
  output logic [15:0]                dbg_grants,
  output logic [15:0]                cpu_stalls,
  output logic [15:0]                dbg_stalls
`endif
);

  localparam int AW = 2 * MEM_ADDR_SIZE;
  localparam int DW = 2 * WORD_SIZE;

  typedef enum logic {ARB, LOCK} state_t;
  localparam logic [1:0] OWN_NONE = 2'd0, OWN_L = 2'd1, OWN_C = 2'd2, OWN_D = 2'd3;
  localparam logic RR_C = 1'b0, RR_D = 1'b1;

  state_t          state, state_next;
  logic            rr;
  logic [1:0]      owner;
  logic            rd_zero;

  logic            any_gnt;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [1:0]      sel_owner;
  logic            bad_addr;
  logic            serve_locked;

  // A trit is encoded in two bits; 2'b11 is not a valid trit.
  function automatic logic addr_illegal(input logic [AW-1:0] a);
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      if (a[2*i +: 2] == 2'b11) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Loader keeps exclusive service only while it still holds ld_lock; the
  // cycle ld_lock drops is already arbitrated normally.
  assign serve_locked = (state == LOCK) && ld_lock;
  assign locked       = (state == LOCK);

  always_ff @(posedge clock) begin
    if (!reset) state <= ARB;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (ld_gnt && ld_lock) state_next = LOCK;
      LOCK:    if (!ld_lock)          state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_comb begin
    ld_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      if (ld_req) begin
        ld_gnt = 1'b1;
      end else if (!serve_locked) begin
        if (cpu_req && (!dbg_req || rr == RR_C)) cpu_gnt = 1'b1;
        else if (dbg_req)                        dbg_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    any_gnt   = ld_gnt | cpu_gnt | dbg_gnt;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_owner = OWN_NONE;
    if (ld_gnt) begin
      sel_we = ld_we;  sel_addr = ld_addr;  sel_wdata = ld_wdata;  sel_owner = OWN_L;
    end else if (cpu_gnt) begin
      sel_we = cpu_we; sel_addr = cpu_addr; sel_wdata = cpu_wdata; sel_owner = OWN_C;
    end else if (dbg_gnt) begin
      sel_we = dbg_we; sel_addr = dbg_addr; sel_wdata = dbg_wdata; sel_owner = OWN_D;
    end
    bad_addr = any_gnt && addr_illegal(sel_addr);
  end

  assign mem_address    = sel_addr;
  assign mem_write_data = sel_wdata;
  assign mem_write      = any_gnt &&  sel_we && !bad_addr;
  assign mem_read       = any_gnt && !sel_we && !bad_addr;

  // Illegal reads never reach RAM, so their return is forced to zero
  // instead of exposing whatever mem_read_data last held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr       <= RR_C;
      owner    <= OWN_NONE;
      rd_zero  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (cpu_gnt)      rr <= RR_D;
      else if (dbg_gnt) rr <= RR_C;
      owner    <= (any_gnt && !sel_we) ? sel_owner : OWN_NONE;
      rd_zero  <= any_gnt && !sel_we && bad_addr;
      addr_err <= bad_addr;
    end
  end

  assign ld_rvalid  = (owner == OWN_L);
  assign cpu_rvalid = (owner == OWN_C);
  assign dbg_rvalid = (owner == OWN_D);
  assign rdata      = rd_zero ? '0 : mem_read_data;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      ld_grants  <= '0;
      cpu_grants <= '0;
      dbg_grants <= '0;
      cpu_stalls <= '0;
      dbg_stalls <= '0;
    end else begin
      if (ld_gnt  && ld_grants  != 16'hFFFF) ld_grants  <= ld_grants  + 16'd1;
      if (cpu_gnt && cpu_grants != 16'hFFFF) cpu_grants <= cpu_grants + 16'd1;
      if (dbg_gnt && dbg_grants != 16'hFFFF) dbg_grants <= dbg_grants + 16'd1;
      if (cpu_req && !cpu_gnt && cpu_stalls != 16'hFFFF) cpu_stalls <= cpu_stalls + 16'd1;
      if (dbg_req && !dbg_gnt && dbg_stalls != 16'hFFFF) dbg_stalls <= dbg_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

  localparam int P_NONE = 0, P_L = 1, P_C = 2, P_D = 3;

  typedef struct {
    int          port;
    logic [17:0] data;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_req, cpu_req, dbg_req;
  logic        ld_we, cpu_we, dbg_we;
  logic [17:0] ld_addr, cpu_addr, dbg_addr;
  logic [17:0] ld_wdata, cpu_wdata, dbg_wdata;
  logic        ld_lock;
  logic        ld_gnt, cpu_gnt, dbg_gnt;
  logic        ld_rvalid, cpu_rvalid, dbg_rvalid;
  logic [17:0] rdata;
  logic        addr_err;
  logic [17:0] mem_address, mem_write_data;
  logic        mem_write, mem_read;
  logic [17:0] mem_read_data;
  logic        locked;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] ld_grants, cpu_grants, dbg_grants, cpu_stalls, dbg_stalls;
`endif

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [17:0] model_mem [logic [17:0]];
  logic        mrr;

  logic [17:0] ram [0:262143];
  logic [17:0] ram_q = '0;
  assign mem_read_data = ram_q;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write) ram[mem_address] <= mem_write_data;
    if (mem_read)  ram_q <= ram[mem_address];
  end

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ld_req(ld_req), .cpu_req(cpu_req), .dbg_req(dbg_req),
    .ld_we(ld_we), .cpu_we(cpu_we), .dbg_we(dbg_we),
    .ld_addr(ld_addr), .cpu_addr(cpu_addr), .dbg_addr(dbg_addr),
    .ld_wdata(ld_wdata), .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
    .ld_lock(ld_lock),
    .ld_gnt(ld_gnt), .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt),
    .ld_rvalid(ld_rvalid), .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .addr_err(addr_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .locked(locked)
`ifdef MEM_ARB_STATS_EN
    , .ld_grants(ld_grants), .cpu_grants(cpu_grants), .dbg_grants(dbg_grants),
    .cpu_stalls(cpu_stalls), .dbg_stalls(dbg_stalls)
`endif
  );

  task automatic clear_inputs();
    ld_req = 0; cpu_req = 0; dbg_req = 0;
    ld_we = 0; cpu_we = 0; dbg_we = 0;
    ld_addr = '0; cpu_addr = '0; dbg_addr = '0;
    ld_wdata = '0; cpu_wdata = '0; dbg_wdata = '0;
    ld_lock = 0;
  endtask

  // Advance one cycle, then pop the return expected for the cycle just granted.
  task automatic tick();
    exp_t       e;
    logic [2:0] want, got;
    @(posedge clock); #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: no expectation queued");
    end else begin
      e = sb.pop_front();
      want = (e.port == P_L) ? 3'b100 : (e.port == P_C) ? 3'b010 :
             (e.port == P_D) ? 3'b001 : 3'b000;
      got = {ld_rvalid, cpu_rvalid, dbg_rvalid};
      total++;
      if (got !== want) begin bad++; $display("FAIL rvalid: got=%b want=%b", got, want); end
      total++;
      if (addr_err !== e.err) begin bad++; $display("FAIL addr_err: got=%b want=%b", addr_err, e.err); end
      if (e.port != P_NONE) begin
        total++;
        if (rdata !== e.data) begin bad++; $display("FAIL rdata: got=%h want=%h", rdata, e.data); end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    ld_req = 1; ld_we = 1; ld_addr = 18'h0; ld_wdata = 18'h0;
    cpu_req = 1; dbg_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({ld_gnt, cpu_gnt, dbg_gnt} !== 3'b000) begin bad++; $display("FAIL reset_gnt: got=%b want=000", {ld_gnt, cpu_gnt, dbg_gnt}); end
      total++;
      if ({mem_write, mem_read} !== 2'b00) begin bad++; $display("FAIL reset_strobe: got=%b want=00", {mem_write, mem_read}); end
      sb.push_back('{P_NONE, 18'h0, 1'b0});
      tick();
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got=%b want=0", locked); end
    end
    mrr = 0;
    reset = 1;
    #1;
    total++;
    if ({ld_gnt, cpu_gnt, dbg_gnt, mem_write} !== 4'b1001) begin bad++; $display("FAIL reset_release: got=%b want=1001", {ld_gnt, cpu_gnt, dbg_gnt, mem_write}); end
    model_mem[18'h0] = 18'h0;
    sb.push_back('{P_NONE, 18'h0, 1'b0});
    tick();
`ifdef MEM_ARB_STATS_EN
    total++;
    if ({ld_grants, cpu_grants, cpu_stalls, dbg_stalls} !== {16'd1, 16'd0, 16'd1, 16'd1}) begin
      bad++; $display("FAIL stats_after_release: got=%h want=0001000000010001", {ld_grants, cpu_grants, cpu_stalls, dbg_stalls});
    end
`endif
    clear_inputs();
  endtask

  task automatic test_priority();
    ld_req = 1; ld_we = 1; ld_addr = 18'h0; ld_wdata = 18'h00015;
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h0;
    #1;
    total++;
    if ({ld_gnt, cpu_gnt, dbg_gnt} !== 3'b100) begin bad++; $display("FAIL prio_gnt: got=%b want=100", {ld_gnt, cpu_gnt, dbg_gnt}); end
    total++;
    if ({mem_write, mem_read, mem_address, mem_write_data} !== {2'b10, 18'h0, 18'h00015}) begin
      bad++; $display("FAIL prio_ram: got=%b %h %h want=10 00000 00015", {mem_write, mem_read}, mem_address, mem_write_data);
    end
    model_mem[18'h0] = 18'h00015;
    sb.push_back('{P_NONE, 18'h0, 1'b0});
    tick();
    ld_req = 0;
    #1;
    total++;
    if ({ld_gnt, cpu_gnt, dbg_gnt, mem_read} !== 4'b0101) begin bad++; $display("FAIL prio_cpu_after: got=%b want=0101", {ld_gnt, cpu_gnt, dbg_gnt, mem_read}); end
    sb.push_back('{P_C, model_mem[18'h0], 1'b0});
    mrr = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [17:0] a [4];
    logic [17:0] d [4];
    int          ci, di;
    logic [2:0]  want;
    a[0] = 18'h00001; a[1] = 18'h00004; a[2] = 18'h00002; a[3] = 18'h00005;
    d[0] = 18'h12345; d[1] = 18'h0ABCD; d[2] = 18'h2A5A5; d[3] = 18'h05A5A;
    for (int i = 0; i < 4; i++) begin
      ld_req = 1; ld_we = 1; ld_addr = a[i]; ld_wdata = d[i];
      #1;
      total++;
      if ({ld_gnt, mem_write} !== 2'b11) begin bad++; $display("FAIL rr_fill: got=%b want=11", {ld_gnt, mem_write}); end
      model_mem[a[i]] = d[i];
      sb.push_back('{P_NONE, 18'h0, 1'b0});
      tick();
    end
    clear_inputs();
    ci = 0; di = 2;
    cpu_req = 1; dbg_req = 1;
    for (int k = 0; k < 6; k++) begin
      cpu_addr = a[ci]; dbg_addr = a[di];
      #1;
      want = (mrr == 0) ? 3'b010 : 3'b001;
      total++;
      if ({ld_gnt, cpu_gnt, dbg_gnt} !== want) begin bad++; $display("FAIL rr_gnt%0d: got=%b want=%b", k, {ld_gnt, cpu_gnt, dbg_gnt}, want); end
      if (mrr == 0) begin
        sb.push_back('{P_C, model_mem[a[ci]], 1'b0});
        ci = (ci == 0) ? 1 : 0;
        mrr = 1;
      end else begin
        sb.push_back('{P_D, model_mem[a[di]], 1'b0});
        di = (di == 2) ? 3 : 2;
        mrr = 0;
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    logic [17:0] la [4];
    la[0] = 18'h00010; la[1] = 18'h00011; la[2] = 18'h00012; la[3] = 18'h00014;
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00010;
    for (int i = 0; i < 4; i++) begin
      ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = la[i]; ld_wdata = 18'h20000 + 18'(i);
      #1;
      total++;
      if ({ld_gnt, cpu_gnt, mem_write} !== 3'b101) begin bad++; $display("FAIL lock_gnt%0d: got=%b want=101", i, {ld_gnt, cpu_gnt, mem_write}); end
      total++;
      if (locked !== (i != 0)) begin bad++; $display("FAIL lock_locked%0d: got=%b want=%b", i, locked, (i != 0)); end
      model_mem[la[i]] = 18'h20000 + 18'(i);
      sb.push_back('{P_NONE, 18'h0, 1'b0});
      tick();
    end
    ld_req = 0; ld_lock = 0;
    #1;
    total++;
    if ({locked, cpu_gnt, mem_read, mem_address} !== {3'b111, 18'h00010}) begin
      bad++; $display("FAIL lock_release: got=%b %h want=111 00010", {locked, cpu_gnt, mem_read}, mem_address);
    end
    sb.push_back('{P_C, model_mem[18'h00010], 1'b0});
    mrr = 1;
    tick();
    clear_inputs();
    #1;
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_exit: got=%b want=0", locked); end
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_we = 1; cpu_addr = 18'h00020; cpu_wdata = 18'h1F0F0;
    #1;
    total++;
    if ({cpu_gnt, mem_write} !== 2'b11) begin bad++; $display("FAIL b2b_write: got=%b want=11", {cpu_gnt, mem_write}); end
    model_mem[18'h00020] = 18'h1F0F0;
    mrr = 1;
    sb.push_back('{P_NONE, 18'h0, 1'b0});
    tick();
    clear_inputs();
    dbg_req = 1; dbg_we = 0; dbg_addr = 18'h00020;
    #1;
    total++;
    if ({dbg_gnt, mem_read} !== 2'b11) begin bad++; $display("FAIL b2b_dbg: got=%b want=11", {dbg_gnt, mem_read}); end
    sb.push_back('{P_D, model_mem[18'h00020], 1'b0});
    mrr = 0;
    tick();
    clear_inputs();
    ld_req = 1; ld_we = 0; ld_addr = 18'h00001;
    #1;
    total++;
    if ({ld_gnt, mem_read} !== 2'b11) begin bad++; $display("FAIL b2b_ld: got=%b want=11", {ld_gnt, mem_read}); end
    sb.push_back('{P_L, model_mem[18'h00001], 1'b0});
    tick();
    clear_inputs();
  endtask

  task automatic test_illegal();
    dbg_req = 1; dbg_we = 0; dbg_addr = 18'h00003;
    #1;
    total++;
    if ({dbg_gnt, mem_read, mem_write} !== 3'b100) begin bad++; $display("FAIL ill_read: got=%b want=100", {dbg_gnt, mem_read, mem_write}); end
    sb.push_back('{P_D, 18'h0, 1'b1});
    mrr = 0;
    tick();
    clear_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 18'h0000C; cpu_wdata = 18'h3FFFF;
    #1;
    total++;
    if ({cpu_gnt, mem_write, mem_read} !== 3'b100) begin bad++; $display("FAIL ill_write: got=%b want=100", {cpu_gnt, mem_write, mem_read}); end
    sb.push_back('{P_NONE, 18'h0, 1'b1});
    mrr = 1;
    tick();
    clear_inputs();
    #1;
    total++;
    if ({ld_gnt, cpu_gnt, dbg_gnt, mem_write, mem_read, mem_address, mem_write_data} !== 41'h0) begin
      bad++; $display("FAIL idle_out: got=%b %h %h want=00000 00000 00000", {ld_gnt, cpu_gnt, dbg_gnt, mem_write, mem_read}, mem_address, mem_write_data);
    end
    sb.push_back('{P_NONE, 18'h0, 1'b0});
    tick();
  endtask

  task automatic test_reset_mid();
    ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 18'h00021; ld_wdata = 18'h0ABCD;
    #1;
    model_mem[18'h00021] = 18'h0ABCD;
    sb.push_back('{P_NONE, 18'h0, 1'b0});
    tick();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL mid_locked: got=%b want=1", locked); end
    ld_we = 0;
    cpu_req = 1; cpu_addr = 18'h00021; dbg_req = 1; dbg_addr = 18'h00021;
    #1;
    total++;
    if ({ld_gnt, cpu_gnt, dbg_gnt, mem_read} !== 4'b1001) begin bad++; $display("FAIL mid_read: got=%b want=1001", {ld_gnt, cpu_gnt, dbg_gnt, mem_read}); end
    #4 reset = 0;
    #1;
    total++;
    if ({ld_gnt, cpu_gnt, dbg_gnt, mem_write, mem_read} !== 5'b0) begin bad++; $display("FAIL mid_reset_gnt: got=%b want=00000", {ld_gnt, cpu_gnt, dbg_gnt, mem_write, mem_read}); end
    sb.push_back('{P_NONE, 18'h0, 1'b0});
    tick();
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL mid_unlock: got=%b want=0", locked); end
`ifdef MEM_ARB_STATS_EN
    total++;
    if ({ld_grants, cpu_grants, dbg_grants, cpu_stalls, dbg_stalls} !== 80'h0) begin
      bad++; $display("FAIL mid_stats: got=%h want=0", {ld_grants, cpu_grants, dbg_grants, cpu_stalls, dbg_stalls});
    end
`endif
    mrr = 0;
    reset = 1; ld_req = 0; ld_lock = 0;
    #1;
    total++;
    if ({ld_gnt, cpu_gnt, dbg_gnt} !== 3'b010) begin bad++; $display("FAIL mid_rr_reset: got=%b want=010", {ld_gnt, cpu_gnt, dbg_gnt}); end
    sb.push_back('{P_C, model_mem[18'h00021], 1'b0});
    mrr = 1;
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
